// File: rtl/minority_pkg.sv
// minority_pkg: shared constants and the three-input vote helper.
//   CNT_W_DEFAULT : default width of the per-input dissent counters.
//   vote3()       : returns {majority, dissent[2:0]} for three input copies.
package minority_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // The majority is computed as a0 ? (a1|a2) : (a1&a2).
  // Dissent is each input XORed with the majority. When all three
  // inputs agree, every XOR is 0. When they do not agree, exactly
  // one input differs from the 2-of-3 result, so the flag is one-hot.
  function automatic logic [3:0] vote3(input logic a0, input logic a1, input logic a2);
    logic       maj;
    logic [2:0] dis;
    maj = a0 ? (a1 | a2) : (a1 & a2);
    dis = {a2 ^ maj, a1 ^ maj, a0 ^ maj};
    return {maj, dis};
  endfunction

endpackage

// File: rtl/minority_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (count -> 0)
//   clr   : synchronous clear (count -> 0), lower priority than reset
//   inc   : increment by one when not already saturated
//   cnt   : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/minority.sv
// minority: 2-of-3 bit voter for triple-redundant signals, with a registered
// health-monitoring side. Despite the name, y is the MAJORITY of the inputs.
//   a0, a1, a2 : redundant copies of one bit
//   y          : combinational majority (independent of clock/reset/en/clr)
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   en         : enables registered-side updates
//   clr        : synchronous clear of dissent flags and counters
//   y_q        : registered majority
//   dissent_q  : registered one-hot flag of the input that disagrees (000 if unanimous)
//   cnt0_q..cnt2_q : saturating per-input dissent counts
// The first four ports are a0, a1, a2, y. A positional hookup that
// connects only those four ports still gives a working combinational voter.
module minority
  import minority_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             a0,
  input  logic             a1,
  input  logic             a2,
  output logic             y,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             y_q,
  output logic [2:0]       dissent_q,
  output logic [CNT_W-1:0] cnt0_q,
  output logic [CNT_W-1:0] cnt1_q,
  output logic [CNT_W-1:0] cnt2_q
);

  logic [3:0] vote;
  logic [2:0] dissent;
  logic [2:0] inc;

  assign vote    = vote3(a0, a1, a2);
  assign y       = vote[3];
  assign dissent = vote[2:0];

  // A counter is bumped only on an enabled edge where its input dissents.
  // clr takes precedence inside the counter itself.
  assign inc = {3{en}} & dissent;

  // clr wipes the health state, but y_q still tracks the vote when
  // enabled. The cleared cycle then shows the current output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      dissent_q <= 3'b000;
    end else if (clr) begin
      dissent_q <= 3'b000;
      if (en) y_q <= y;
    end else if (en) begin
      y_q       <= y;
      dissent_q <= dissent;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc[0]),
    .cnt   (cnt0_q)
  );

  sat_counter #(.W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc[1]),
    .cnt   (cnt1_q)
  );

  sat_counter #(.W(CNT_W)) u_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc[2]),
    .cnt   (cnt2_q)
  );

endmodule

// File: tb/tb_minority.sv
// tb_minority: self-checking bench for minority. Two instances share the
// inputs: u_dut with default 8-bit counters and u_sat with 2-bit counters,
// which are used for saturation.
module tb_minority;

  localparam int EW = 38;

  logic clk;
  logic a0, a1, a2;
  logic rst_n, en, clr;

  logic       y, y_q;
  logic [2:0] dissent_q;
  logic [7:0] cnt0_q, cnt1_q, cnt2_q;

  logic       s_y, s_yq;
  logic [2:0] s_dis;
  logic [1:0] s_cnt0, s_cnt1, s_cnt2;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp;

  // reference model state
  logic       m_yq;
  logic [2:0] m_dis;
  logic [7:0] m_c [3];
  logic [1:0] s_c [3];

  minority u_dut (
    .a0(a0), .a1(a1), .a2(a2), .y(y),
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .y_q(y_q), .dissent_q(dissent_q),
    .cnt0_q(cnt0_q), .cnt1_q(cnt1_q), .cnt2_q(cnt2_q)
  );

  minority #(.CNT_W(2)) u_sat (
    .a0(a0), .a1(a1), .a2(a2), .y(s_y),
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .y_q(s_yq), .dissent_q(s_dis),
    .cnt0_q(s_cnt0), .cnt1_q(s_cnt1), .cnt2_q(s_cnt2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [EW-1:0] observed();
    return {y_q, dissent_q, s_yq, s_dis, cnt0_q, cnt1_q, cnt2_q, s_cnt0, s_cnt1, s_cnt2};
  endfunction

  function automatic logic model_maj(input logic [2:0] a);
    return (int'(a[0]) + int'(a[1]) + int'(a[2])) >= 2;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of stimulus and advance the model. Push the expected
  // registered state, then wait until just after the sampling edge.
  task automatic step(input logic [2:0] a, input logic e, input logic c, input logic r);
    logic       maj;
    logic [2:0] d;
    {a2, a1, a0} = a;
    en = e; clr = c; rst_n = r;
    maj = model_maj(a);
    d = 3'b000;
    if (a != 3'b000 && a != 3'b111)
      for (int i = 0; i < 3; i++) if (a[i] != maj) d[i] = 1'b1;
    if (!r) begin
      m_yq = 1'b0; m_dis = 3'b000;
      for (int i = 0; i < 3; i++) begin m_c[i] = 8'd0; s_c[i] = 2'd0; end
    end else if (c) begin
      m_dis = 3'b000;
      if (e) m_yq = maj;
      for (int i = 0; i < 3; i++) begin m_c[i] = 8'd0; s_c[i] = 2'd0; end
    end else if (e) begin
      m_yq = maj; m_dis = d;
      for (int i = 0; i < 3; i++) if (d[i]) begin
        if (m_c[i] != 8'hFF) m_c[i] = m_c[i] + 8'd1;
        if (s_c[i] != 2'd3)  s_c[i] = s_c[i] + 2'd1;
      end
    end
    exp_q.push_back({m_yq, m_dis, m_yq, m_dis, m_c[0], m_c[1], m_c[2], s_c[0], s_c[1], s_c[2]});
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_sweep();
    logic [7:0] req;
    req = 8'b1110_1000;
    en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a2, a1, a0} = 3'(i);
      #10;
      checks++;
      if (y !== req[i] || s_y !== req[i]) begin
        errors++;
        $display("FAIL sweep a=%0d: y=%b s_y=%b required %b", i, y, s_y, req[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; {a2, a1, a0} = 3'b111;
    #1;
    checks++;
    if (y !== 1'b1) begin
      errors++; $display("FAIL reset_y_immediate: y=%b required 1", y);
    end
    for (int i = 0; i < 2; i++) begin
      step(3'b111, 1'b0, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp) begin
        errors++; $display("FAIL reset edge %0d: got %h required %h", i, observed(), exp);
      end
    end
    checks++;
    if ({y_q, dissent_q, cnt0_q, cnt1_q, cnt2_q} !== 28'd0 || y !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: y=%b y_q=%b dis=%b c=%0d/%0d/%0d required y=1 rest 0",
               y, y_q, dissent_q, cnt0_q, cnt1_q, cnt2_q);
    end
  endtask

  task automatic test_dissent();
    for (int i = 0; i < 3; i++) begin
      step(3'b001, 1'b1, 1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp) begin
        errors++; $display("FAIL dissent edge %0d: got %h required %h", i, observed(), exp);
      end
    end
    checks++;
    if (y !== 1'b0 || dissent_q !== 3'b001 || cnt0_q !== 8'd3 || cnt1_q !== 8'd0 || cnt2_q !== 8'd0) begin
      errors++;
      $display("FAIL dissent_a0: y=%b dis=%b c=%0d/%0d/%0d required y=0 dis=001 c=3/0/0",
               y, dissent_q, cnt0_q, cnt1_q, cnt2_q);
    end
    step(3'b111, 1'b1, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp || dissent_q !== 3'b000 || cnt0_q !== 8'd3) begin
      errors++;
      $display("FAIL unanimous_hold: dis=%b cnt0=%0d required dis=000 cnt0=3", dissent_q, cnt0_q);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      step(3'b101, 1'b1, 1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp) begin
        errors++; $display("FAIL saturation edge %0d: got %h required %h", i, observed(), exp);
      end
    end
    checks++;
    if (s_cnt1 !== 2'd3 || cnt1_q !== 8'd6 || s_dis !== 3'b010) begin
      errors++;
      $display("FAIL saturate_cnt1: small=%0d wide=%0d dis=%b required 3 / 6 / 010", s_cnt1, cnt1_q, s_dis);
    end
  endtask

  task automatic test_enable_clear();
    logic [2:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 3'($urandom_range(0, 7));
      step(a, 1'b0, 1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp || y !== model_maj(a)) begin
        errors++;
        $display("FAIL enable_hold edge %0d: got %h y=%b required %h y=%b", i, observed(), y, exp, model_maj(a));
      end
    end
    step(3'b011, 1'b1, 1'b1, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp || y_q !== 1'b1 || dissent_q !== 3'b000 ||
        {cnt0_q, cnt1_q, cnt2_q} !== 24'd0) begin
      errors++;
      $display("FAIL clear: y_q=%b dis=%b c=%0d/%0d/%0d required y_q=1 dis=000 c=0",
               y_q, dissent_q, cnt0_q, cnt1_q, cnt2_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    logic       e, c;
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0);
      step(a, e, c, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp || y !== model_maj(a)) begin
        errors++;
        $display("FAIL random edge %0d a=%b en=%b clr=%b: got %h required %h", i, a, e, c, observed(), exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      step(3'b110, 1'b1, 1'b0, 1'b1);
      exp = exp_q.pop_front();
    end
    checks++;
    if (cnt0_q === 8'd0 || observed() !== exp) begin
      errors++; $display("FAIL premid_nonzero: cnt0=%0d got %h required nonzero, %h", cnt0_q, observed(), exp);
    end
    // reset together with clr and en must still behave as reset
    step(3'b110, 1'b1, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp || {y_q, dissent_q, cnt0_q, cnt1_q, cnt2_q} !== 28'd0 || y !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: y=%b y_q=%b dis=%b c=%0d/%0d/%0d required y=1 rest 0",
               y, y_q, dissent_q, cnt0_q, cnt1_q, cnt2_q);
    end
    step(3'b000, 1'b1, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++; $display("FAIL post_reset: got %h required %h", observed(), exp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    {a2, a1, a0} = 3'b000;
    rst_n = 1'b1; en = 1'b0; clr = 1'b0;
    m_yq = 1'b0; m_dis = 3'b000;
    for (int i = 0; i < 3; i++) begin m_c[i] = 8'd0; s_c[i] = 2'd0; end
    test_sweep();
    test_reset();
    test_dissent();
    test_saturation();
    test_enable_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
